axi_lite_mem_slave: RTL
=======================

# axi_lite_mem_slave

Single-port AXI4-Lite-style memory slave that sits directly downstream of the core's memory interface. It serves both instruction fetches and data loads and stores. It answers the AR/R and AW/W/B handshakes with configurable latency, so bench and formal environments can exercise every wait state of the master FSM. Storage is a word array with byte-strobe writes; an out-of-range access raises a sticky error flag.

## Interface
Parameters:
- DEPTH_WORDS, 1024 — number of 32-bit words; power of two.
- RD_LAT, 0 — extra cycles between the AR handshake and Rvalid; range 0..15.
- WR_LAT, 0 — extra cycles between both write halves being captured and Bvalid; range 0..15.
- INIT_FILE, "" — if non-empty, loaded with $readmemh at time 0.

Ports:
- clock  in  1  clock; all state on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ARvalid  in  1  read address valid.
- ARdata  in  32  read byte address.
- arprot  in  3  ignored; arprot[2]=1 marks a fetch.
- ARready  out  1  read address accepted.
- Rvalid  out  1  read data valid.
- RReady  in  1  master accepts read data.
- Rdata_mem  out  32  read data, full word.
- AWvalid  in  1  write address valid.
- AWdata  in  32  write byte address.
- awprot  in  3  ignored.
- AWready  out  1  write address accepted.
- Wvalid  in  1  write data valid.
- Wdata  in  32  write data.
- Wstrb  in  4  byte enables; bit i enables Wdata[8i+7:8i].
- Wready  out  1  write data accepted.
- Bvalid  out  1  write response valid.
- Bready  in  1  master accepts response.
- err  out  1  sticky: an out-of-range address was accepted.

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored; the master does lane selection.
- Out of range means addr[31:log2(DEPTH_WORDS)+2] != 0. Such a read returns 32'h0; such a write is dropped. Both set err.
- Read and write channels are independent FSMs and may be busy at the same time.

Read FSM:
- R_IDLE: ARready=1. On ARvalid&ARready, latch the address and load cnt=RD_LAT.
  - Go to R_RESP if RD_LAT=0; otherwise go to R_WAIT.
- R_WAIT: ARready=0. Decrement cnt each cycle; move to R_RESP when cnt reaches 1.
- Entering R_RESP samples the array into Rdata_mem. In R_RESP: Rvalid=1, ARready=0.
- Rdata_mem and Rvalid stay stable until RReady. On Rvalid&RReady, go to R_IDLE.

Write FSM:
- W_IDLE: AWready=1, Wready=1.
  - AWvalid&AWready captures the address and drops AWready.
  - Wvalid&Wready captures data and strobe and drops Wready.
  - The two may happen in the same cycle or in either order.
- W_HALF: exactly one half captured. Keep the missing ready high until it is captured.
- When both halves are held, load cnt=WR_LAT. Go to W_WAIT, or straight to W_RESP if WR_LAT=0.
- W_WAIT: count down to 1, then go to W_RESP.
- The array update (strobed bytes only) happens on the edge that enters W_RESP.
- W_RESP: Bvalid=1 until Bready, then W_IDLE with both readies high.

Simultaneous events:
- A read entering R_RESP on the same edge a write to the same word enters W_RESP returns pre-write data.
- A later read returns the new data.

Reset:
- When resetn=0 at an edge, both FSMs return to idle and all pending transactions are abandoned.
- A write not yet in W_RESP never commits. Array contents are preserved.

## Timing
- Reset values: ARready=1, AWready=1, Wready=1, Rvalid=0, Bvalid=0, Rdata_mem=0, err=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Read latency: AR handshake at edge N gives Rvalid high in cycle N+1+RD_LAT.
- Write latency: the later half is captured at edge N; Bvalid is high in cycle N+1+WR_LAT.
- Back-to-back accesses:
  - ARready returns in the cycle after the R handshake, so at most one read every 2 cycles at RD_LAT=0.
  - Writes likewise.
- Holding RReady or Bready low stalls indefinitely; the outputs stay stable.

## Test plan
- Full write, then read: RD_LAT=WR_LAT=0, write 0xDEADBEEF to 0x10 with Wstrb=1111.
  - Required: Bvalid one cycle after the handshake.
  - Read 0x10: Rvalid at N+1 with Rdata_mem=0xDEADBEEF.
- Byte strobe: pre-load 0x11223344 at 0x20, write 0xAAAAAAAA with Wstrb=0100.
  - Required: a read of 0x20 returns 0x11AA3344.
- Split write halves: AWvalid at cycle 0, Wvalid delayed to cycle 3, WR_LAT=2.
  - Required: AWready low from cycle 1, Wready stays high until cycle 3, Bvalid at cycle 6.
  - Required: memory unchanged before that edge.
- Read latency with backpressure: RD_LAT=3, AR handshake at edge N, RReady held low 4 cycles.
  - Required: Rvalid rises at N+4, data stable while stalled.
  - Required: ARready stays 0 until the cycle after the R handshake.
- Same-word collision: read and write of 0x40 (old 0x5, new 0x9) enter their response states on the same edge.
  - Required: the read returns 0x5; the next read returns 0x9.
- Out of range and reset:
  - Read 0x0001_0000 with DEPTH_WORDS=1024: Rdata_mem=0, err=1 and stays 1.
  - Assert resetn=0 during W_WAIT: Bvalid never rises, the target word is unchanged, readies return to 1 after reset.

Source files
------------

// File: rtl/axi_lite_mem_slave_if.sv
// Bus bundle between the core's memory master and axi_lite_mem_slave.
// Read address/data, write address/data/response channels plus the sticky error flag.
interface axi_lite_mem_slave_if;
    logic        ARvalid;
    logic [31:0] ARdata;
    logic [2:0]  arprot;
    logic        ARready;
    logic        Rvalid;
    logic        RReady;
    logic [31:0] Rdata_mem;
    logic        AWvalid;
    logic [31:0] AWdata;
    logic [2:0]  awprot;
    logic        AWready;
    logic        Wvalid;
    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Wready;
    logic        Bvalid;
    logic        Bready;
    logic        err;

    modport master (
        output ARvalid, ARdata, arprot, RReady,
        output AWvalid, AWdata, awprot, Wvalid, Wdata, Wstrb, Bready,
        input  ARready, Rvalid, Rdata_mem, AWready, Wready, Bvalid, err
    );

    modport slave (
        input  ARvalid, ARdata, arprot, RReady,
        input  AWvalid, AWdata, awprot, Wvalid, Wdata, Wstrb, Bready,
        output ARready, Rvalid, Rdata_mem, AWready, Wready, Bvalid, err
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// Single-port AXI4-Lite-style word memory with independent read/write FSMs,
// configurable response latency, byte-strobe writes and a sticky out-of-range flag.
module axi_lite_mem_slave #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    RD_LAT      = 0,
    parameter int    WR_LAT      = 0,
    parameter string INIT_FILE   = ""
) (
    input logic                 clock,
    input logic                 resetn,
    axi_lite_mem_slave_if.slave bus
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WAIT = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic out_of_range(input logic [31:0] a);
        return |a[31:IDX_W+2];
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return a[IDX_W+1:2];
    endfunction

    // Protection bits and byte offset carry no meaning for this memory.
    logic unused_bits;
    assign unused_bits = ^{bus.arprot, bus.awprot, bus.ARdata[1:0], bus.AWdata[1:0]};

    // ---------------- read channel ----------------
    logic [1:0]  r_state_reg, r_state_next;
    logic [3:0]  r_cnt_reg, r_cnt_next;
    logic [31:0] r_addr_reg, r_addr_next;
    logic [31:0] r_addr_use;
    logic [31:0] rdata_reg;
    logic        ar_ready_reg, r_valid_reg;
    logic        ar_fire, r_load;

    assign ar_fire = bus.ARvalid && ar_ready_reg;

    always_comb begin
        r_state_next = r_state_reg;
        r_cnt_next   = r_cnt_reg;
        r_addr_next  = r_addr_reg;
        r_addr_use   = r_addr_reg;
        r_load       = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_fire) begin
                    r_addr_next = bus.ARdata;
                    r_addr_use  = bus.ARdata;
                    r_cnt_next  = RD_LAT_C;
                    if (RD_LAT == 0) begin
                        r_state_next = R_RESP;
                        r_load       = 1'b1;
                    end else begin
                        r_state_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_reg <= 4'd1) begin
                    r_state_next = R_RESP;
                    r_load       = 1'b1;
                end else begin
                    r_cnt_next = r_cnt_reg - 4'd1;
                end
            end
            R_RESP: begin
                if (bus.RReady) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state_reg  <= R_IDLE;
            r_cnt_reg    <= 4'd0;
            r_addr_reg   <= 32'd0;
            ar_ready_reg <= 1'b1;
            r_valid_reg  <= 1'b0;
        end else begin
            r_state_reg  <= r_state_next;
            r_cnt_reg    <= r_cnt_next;
            r_addr_reg   <= r_addr_next;
            ar_ready_reg <= (r_state_next == R_IDLE);
            r_valid_reg  <= (r_state_next == R_RESP);
        end
    end

    // Registered array read; a write committing on the same edge is not yet visible.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rdata_reg <= 32'd0;
        end else if (r_load) begin
            rdata_reg <= out_of_range(r_addr_use) ? 32'd0 : mem[word_idx(r_addr_use)];
        end
    end

    // ---------------- write channel ----------------
    logic [1:0]  w_state_reg, w_state_next;
    logic [3:0]  w_cnt_reg, w_cnt_next;
    logic [31:0] w_addr_reg, w_addr_next;
    logic [31:0] w_data_reg, w_data_next;
    logic [3:0]  w_strb_reg, w_strb_next;
    logic        aw_held_reg, aw_held_next;
    logic        w_held_reg, w_held_next;
    logic        aw_ready_reg, w_ready_reg, b_valid_reg;
    logic        aw_fire, w_fire, w_commit;

    assign aw_fire = bus.AWvalid && aw_ready_reg;
    assign w_fire  = bus.Wvalid && w_ready_reg;

    always_comb begin
        w_state_next = w_state_reg;
        w_cnt_next   = w_cnt_reg;
        w_addr_next  = w_addr_reg;
        w_data_next  = w_data_reg;
        w_strb_next  = w_strb_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        w_commit     = 1'b0;
        case (w_state_reg)
            W_IDLE, W_HALF: begin
                if (aw_fire) begin
                    aw_held_next = 1'b1;
                    w_addr_next  = bus.AWdata;
                end
                if (w_fire) begin
                    w_held_next = 1'b1;
                    w_data_next = bus.Wdata;
                    w_strb_next = bus.Wstrb;
                end
                if (aw_held_next && w_held_next) begin
                    w_cnt_next = WR_LAT_C;
                    if (WR_LAT == 0) begin
                        w_state_next = W_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = W_WAIT;
                    end
                end else if (aw_held_next || w_held_next) begin
                    w_state_next = W_HALF;
                end
            end
            W_WAIT: begin
                if (w_cnt_reg <= 4'd1) begin
                    w_state_next = W_RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_reg - 4'd1;
                end
            end
            W_RESP: begin
                if (bus.Bready) begin
                    w_state_next = W_IDLE;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            w_state_reg  <= W_IDLE;
            w_cnt_reg    <= 4'd0;
            w_addr_reg   <= 32'd0;
            w_data_reg   <= 32'd0;
            w_strb_reg   <= 4'd0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_ready_reg <= 1'b1;
            w_ready_reg  <= 1'b1;
            b_valid_reg  <= 1'b0;
        end else begin
            w_state_reg  <= w_state_next;
            w_cnt_reg    <= w_cnt_next;
            w_addr_reg   <= w_addr_next;
            w_data_reg   <= w_data_next;
            w_strb_reg   <= w_strb_next;
            aw_held_reg  <= aw_held_next;
            w_held_reg   <= w_held_next;
            aw_ready_reg <= (w_state_next == W_IDLE || w_state_next == W_HALF) && !aw_held_next;
            w_ready_reg  <= (w_state_next == W_IDLE || w_state_next == W_HALF) && !w_held_next;
            b_valid_reg  <= (w_state_next == W_RESP);
        end
    end

    // Contents survive reset; only a commit on a non-reset edge touches the array.
    always_ff @(posedge clock) begin
        if (resetn && w_commit && !out_of_range(w_addr_next)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_next[b]) mem[word_idx(w_addr_next)][8*b +: 8] <= w_data_next[8*b +: 8];
            end
        end
    end

    logic err_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_reg <= 1'b0;
        end else if ((ar_fire && out_of_range(bus.ARdata)) || (aw_fire && out_of_range(bus.AWdata))) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.ARready   = ar_ready_reg;
    assign bus.Rvalid    = r_valid_reg;
    assign bus.Rdata_mem = rdata_reg;
    assign bus.AWready   = aw_ready_reg;
    assign bus.Wready    = w_ready_reg;
    assign bus.Bvalid    = b_valid_reg;
    assign bus.err       = err_reg;
endmodule
